datapath_mc: RTL and testbench
==============================

DATAPATH_MC -- requirements
Module: datapath_mc

Interface
REQ-001 Parameters SHALL be: W, default 64, data width; NREG, default 32, register count, power of 2; PCW, default 32, PC width; AW, default 32, memory address width; IRW, default 32, instruction register width.
REQ-002 Ports, clock and reset first (name, direction, width, meaning):
- CLK, in, 1, single clock, rising edge.
- RST, in, 1, asynchronous active-low reset.
- cw_valid, in, 1, control word offered.
- cw_ready, out, 1, control word accepted when cw_valid is also high.
- SA, SB, DA, in, $clog2(NREG) each, A-read, B-read and destination register selects.
- WR, in, 1, register write enable.
- FS, in, 3, ALU function.
- C0, in, 1, carry in.
- M, in, 1, B-operand select: 1 = K, 0 = B register.
- K, in, W, constant.
- PS, in, 2, PC op.
- PC_SEL, in, 1, absolute branch source: 0 = A register, 1 = K.
- MOP, in, 2, memory op: 0 none, 1 load, 2 store, 3 fetch.
- mem_req, out, 1, memory request.
- mem_we, out, 1, write.
- mem_addr, out, AW, address.
- mem_wdata, out, W, store data.
- mem_gnt, in, 1, request accepted.
- mem_rvalid, in, 1, read data valid.
- mem_rdata, in, W, read data.
- STAT, out, 4, {V,C,N,Z}.
- PC_OUT, out, PCW, program counter.
- CONSIG, out, IRW, instruction register.
- dbg_sel, in, $clog2(NREG), debug select.
- dbg_data, out, W, combinational register read.

Function
REQ-003 FSM states SHALL be IDLE, MREQ and MWAIT; cw_ready SHALL be 1 only in IDLE.
REQ-004 On accept with MOP=0, the block SHALL complete in that edge: if WR, F is written to DA; STAT and PC are updated; state remains IDLE.
REQ-005 On accept with MOP≠0, the block SHALL latch A, B, F, DA, WR and MOP, update STAT and PC at the same edge, and go to MREQ.
REQ-006 In MREQ, mem_req SHALL be 1 and mem_addr/mem_we/mem_wdata SHALL be held stable until mem_gnt.
REQ-007 On mem_gnt, a store SHALL go to IDLE and a load or fetch SHALL go to MWAIT.
REQ-008 A mem_rvalid arriving in the same cycle as mem_gnt SHALL NOT be consumed.
REQ-009 In MWAIT, on mem_rvalid: a load SHALL write mem_rdata to DA if WR; a fetch SHALL load CONSIG with mem_rdata[IRW-1:0]; then IDLE.
REQ-010 mem_addr SHALL be the pre-update PC zero-extended or truncated to AW for fetch, and F[AW-1:0] for load/store; mem_wdata SHALL be B; mem_we SHALL be 1 only for store.
REQ-011 The operand mux SHALL give MB = M ? K : B.
REQ-012 FS SHALL select: 0 AND; 1 OR; 2 ADD (A+MB+C0); 3 SUB (A+~MB+1); 4 XOR; 5 LSL (A<<MB[5:0]); 6 LSR; 7 pass MB.
REQ-013 STAT flags SHALL be: Z = F==0; N = F[W-1]; C and V from ADD/SUB only, 0 otherwise.
REQ-014 Register NREG-1 SHALL read as zero and ignore writes.
REQ-015 Writes SHALL take effect at the edge; a same-cycle read of the written register SHALL return the old value.
REQ-016 PS SHALL select: 0 hold; 1 PC+4; 2 absolute (PC_SEL ? K : A) truncated to PCW; 3 PC+(K<<2) truncated, wrapping modulo 2^PCW.
REQ-017 dbg_data SHALL be the combinational read of dbg_sel, with NREG-1 reading as zero.
REQ-018 cw_valid outside IDLE SHALL be ignored with no side effect.

Reset
REQ-019 RST low SHALL asynchronously force state IDLE, all registers 0, PC_OUT 0, CONSIG 0, STAT 0 and mem_req 0, including mid-transaction.
REQ-020 After RST rises, the first accept SHALL be possible on the next edge.

Structure
REQ-021 A shared package SHALL hold the FSM state enum, the FS and MOP encodings, and the PS encodings.
REQ-022 The register file SHALL be a separate sub-module regfile_np with parameters W and NREG, 2 read ports, 1 write port and 1 debug read port.

Verification
REQ-023 Scenario: SA=31, M=1, K=5, FS=2, WR=1, DA=1, MOP=0 -> R1=5, STAT=0000, PC unchanged with PS=0.
REQ-024 Scenario: R1=5, SB=1, K=0x100, M=1, FS=7, MOP=2, mem_gnt delayed 3 cycles -> mem_req high for 4 cycles, addr 0x100, wdata 5, cw_ready 0 throughout.
REQ-025 Scenario: fetch with PS=1, PC=0 -> mem_addr=0, PC_OUT=4; mem_rvalid data 0xDEADBEEF -> CONSIG=0xDEADBEEF.
REQ-026 Scenario: SUB of 0 minus 1 -> F=all ones, STAT N=1, Z=0, C=0, V=0; a write to R31 is discarded, dbg_sel=31 -> 0.
REQ-027 Scenario: RST low during MWAIT -> mem_req 0 immediately, state IDLE, and a late mem_rvalid is ignored.
REQ-028 Scenario: PC=0xFFFFFFFC, PS=3, K=1 -> PC_OUT=0 (wrap).

Source files
------------

// File: rtl/datapath_mc_pkg.sv
// Shared encodings for the multi-cycle datapath: FSM states, ALU functions,
// memory ops and PC ops.
// Ports: none (package).
package datapath_mc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MREQ  = 2'd1,
    ST_MWAIT = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    FS_AND  = 3'd0,
    FS_OR   = 3'd1,
    FS_ADD  = 3'd2,
    FS_SUB  = 3'd3,
    FS_XOR  = 3'd4,
    FS_LSL  = 3'd5,
    FS_LSR  = 3'd6,
    FS_PASS = 3'd7
  } fs_t;

  typedef enum logic [1:0] {
    MOP_NONE  = 2'd0,
    MOP_LOAD  = 2'd1,
    MOP_STORE = 2'd2,
    MOP_FETCH = 2'd3
  } mop_t;

  typedef enum logic [1:0] {
    PS_HOLD = 2'd0,
    PS_INC  = 2'd1,
    PS_ABS  = 2'd2,
    PS_REL  = 2'd3
  } ps_t;

endpackage

// File: rtl/datapath_mc_regfile_np.sv
// Register file: NREG x W, two read ports, one debug read port, one write port.
// Ports: clk/rst_n; ra/rb/rdbg read selects -> qa/qb/qdbg (combinational);
//        we/wa/wd write at the rising edge. The top register is hardwired to zero.
module regfile_np #(
  parameter int W    = 64,
  parameter int NREG = 32,
  localparam int SW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [SW-1:0] ra,
  input  logic [SW-1:0] rb,
  input  logic [SW-1:0] rdbg,
  input  logic          we,
  input  logic [SW-1:0] wa,
  input  logic [W-1:0]  wd,
  output logic [W-1:0]  qa,
  output logic [W-1:0]  qb,
  output logic [W-1:0]  qdbg
);

  localparam logic [SW-1:0] ZREG = SW'(NREG - 1);

  logic [W-1:0] regs [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && (wa != ZREG)) begin
      regs[wa] <= wd;
    end
  end

  // Reads see the pre-edge contents, so a same-cycle write is not forwarded.
  assign qa   = (ra   == ZREG) ? '0 : regs[ra];
  assign qb   = (rb   == ZREG) ? '0 : regs[rb];
  assign qdbg = (rdbg == ZREG) ? '0 : regs[rdbg];

endmodule

// File: rtl/datapath_mc.sv
// Multi-cycle datapath: register file, ALU, PC and a memory handshake FSM.
// Ports: CLK/RST(async low); cw_valid/cw_ready control word handshake with
//        SA,SB,DA,WR,FS,C0,M,K,PS,PC_SEL,MOP; mem_* request/grant/read-data;
//        STAT {V,C,N,Z}, PC_OUT, CONSIG; dbg_sel -> dbg_data.
module datapath_mc
  import datapath_mc_pkg::*;
#(
  parameter int W    = 64,
  parameter int NREG = 32,
  parameter int PCW  = 32,
  parameter int AW   = 32,
  parameter int IRW  = 32,
  localparam int SW  = $clog2(NREG)
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           cw_valid,
  output logic           cw_ready,
  input  logic [SW-1:0]  SA,
  input  logic [SW-1:0]  SB,
  input  logic [SW-1:0]  DA,
  input  logic           WR,
  input  logic [2:0]     FS,
  input  logic           C0,
  input  logic           M,
  input  logic [W-1:0]   K,
  input  logic [1:0]     PS,
  input  logic           PC_SEL,
  input  logic [1:0]     MOP,
  output logic           mem_req,
  output logic           mem_we,
  output logic [AW-1:0]  mem_addr,
  output logic [W-1:0]   mem_wdata,
  input  logic           mem_gnt,
  input  logic           mem_rvalid,
  input  logic [W-1:0]   mem_rdata,
  output logic [3:0]     STAT,
  output logic [PCW-1:0] PC_OUT,
  output logic [IRW-1:0] CONSIG,
  input  logic [SW-1:0]  dbg_sel,
  output logic [W-1:0]   dbg_data
);

  state_t         state;
  logic [PCW-1:0] pc_q, pc_next;
  logic [IRW-1:0] consig_q;
  logic [3:0]     stat_q, stat_next;
  logic [AW-1:0]  addr_q;
  logic [W-1:0]   b_q;
  logic [SW-1:0]  da_q;
  logic           wr_q;
  mop_t           mop_q;

  logic [W-1:0]   a, b, mb, f;
  logic [W:0]     sum;
  logic           c_flag, v_flag;
  logic           accept;
  logic           rf_we;
  logic [SW-1:0]  rf_wa;
  logic [W-1:0]   rf_wd;

  assign accept = cw_valid && (state == ST_IDLE);

  // Load data uses the single write port while in MWAIT; no control word can be
  // accepted then, so the two write sources never collide.
  assign rf_we = (accept && (mop_t'(MOP) == MOP_NONE) && WR) ||
                 ((state == ST_MWAIT) && mem_rvalid && (mop_q == MOP_LOAD) && wr_q);
  assign rf_wa = (state == ST_MWAIT) ? da_q : DA;
  assign rf_wd = (state == ST_MWAIT) ? mem_rdata : f;

  regfile_np #(.W(W), .NREG(NREG)) u_rf (
    .clk   (CLK),
    .rst_n (RST),
    .ra    (SA),
    .rb    (SB),
    .rdbg  (dbg_sel),
    .we    (rf_we),
    .wa    (rf_wa),
    .wd    (rf_wd),
    .qa    (a),
    .qb    (b),
    .qdbg  (dbg_data)
  );

  always_comb begin
    mb     = M ? K : b;
    sum    = '0;
    f      = '0;
    c_flag = 1'b0;
    v_flag = 1'b0;
    case (fs_t'(FS))
      FS_AND: f = a & mb;
      FS_OR:  f = a | mb;
      FS_ADD: begin
        sum    = {1'b0, a} + {1'b0, mb} + {{W{1'b0}}, C0};
        f      = sum[W-1:0];
        c_flag = sum[W];
        v_flag = (a[W-1] == mb[W-1]) && (f[W-1] != a[W-1]);
      end
      FS_SUB: begin
        sum    = {1'b0, a} + {1'b0, ~mb} + (W+1)'(1);
        f      = sum[W-1:0];
        c_flag = sum[W];
        v_flag = (a[W-1] != mb[W-1]) && (f[W-1] != a[W-1]);
      end
      FS_XOR: f = a ^ mb;
      FS_LSL: f = a << mb[5:0];
      FS_LSR: f = a >> mb[5:0];
      default: f = mb;
    endcase
    stat_next = {v_flag, c_flag, f[W-1], (f == '0)};
  end

  always_comb begin
    pc_next = pc_q;
    case (ps_t'(PS))
      PS_INC:  pc_next = pc_q + PCW'(4);
      PS_ABS:  pc_next = PC_SEL ? PCW'(K) : PCW'(a);
      PS_REL:  pc_next = pc_q + (PCW'(K) << 2);
      default: pc_next = pc_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= ST_IDLE;
      pc_q     <= '0;
      consig_q <= '0;
      stat_q   <= '0;
      addr_q   <= '0;
      b_q      <= '0;
      da_q     <= '0;
      wr_q     <= 1'b0;
      mop_q    <= MOP_NONE;
    end else begin
      case (state)
        ST_IDLE: if (cw_valid) begin
          stat_q <= stat_next;
          pc_q   <= pc_next;
          if (mop_t'(MOP) != MOP_NONE) begin
            // Fetch addresses with the PC as it was before this edge's update.
            addr_q <= (mop_t'(MOP) == MOP_FETCH) ? AW'(pc_q) : AW'(f);
            b_q    <= b;
            da_q   <= DA;
            wr_q   <= WR;
            mop_q  <= mop_t'(MOP);
            state  <= ST_MREQ;
          end
        end
        ST_MREQ: if (mem_gnt) begin
          state <= (mop_q == MOP_STORE) ? ST_IDLE : ST_MWAIT;
        end
        ST_MWAIT: if (mem_rvalid) begin
          if (mop_q == MOP_FETCH) consig_q <= mem_rdata[IRW-1:0];
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cw_ready  = (state == ST_IDLE);
  assign mem_req   = (state == ST_MREQ);
  assign mem_we    = (state == ST_MREQ) && (mop_q == MOP_STORE);
  assign mem_addr  = addr_q;
  assign mem_wdata = b_q;
  assign STAT      = stat_q;
  assign PC_OUT    = pc_q;
  assign CONSIG    = consig_q;

endmodule

// File: tb/tb_datapath_mc.sv
// Directed bench for datapath_mc with default parameters.
module tb_datapath_mc;

  logic        CLK = 1'b0;
  logic        RST;
  logic        cw_valid;
  logic        cw_ready;
  logic [4:0]  SA, SB, DA;
  logic        WR;
  logic [2:0]  FS;
  logic        C0, M;
  logic [63:0] K;
  logic [1:0]  PS;
  logic        PC_SEL;
  logic [1:0]  MOP;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [63:0] mem_rdata;
  logic [3:0]  STAT;
  logic [31:0] PC_OUT, CONSIG;
  logic [4:0]  dbg_sel;
  logic [63:0] dbg_data;

  int vectors = 0;
  int miscompares = 0;

  datapath_mc dut (
    .CLK(CLK), .RST(RST), .cw_valid(cw_valid), .cw_ready(cw_ready),
    .SA(SA), .SB(SB), .DA(DA), .WR(WR), .FS(FS), .C0(C0), .M(M), .K(K),
    .PS(PS), .PC_SEL(PC_SEL), .MOP(MOP),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .STAT(STAT), .PC_OUT(PC_OUT), .CONSIG(CONSIG),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic setcw(input logic [4:0] sa_i, input logic [4:0] sb_i, input logic [4:0] da_i,
                       input logic wr_i, input logic [2:0] fs_i, input logic c0_i,
                       input logic m_i, input logic [63:0] k_i, input logic [1:0] ps_i,
                       input logic pcsel_i, input logic [1:0] mop_i);
    SA = sa_i; SB = sb_i; DA = da_i; WR = wr_i; FS = fs_i; C0 = c0_i; M = m_i;
    K = k_i; PS = ps_i; PC_SEL = pcsel_i; MOP = mop_i;
    cw_valid = 1'b1;
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  // One accepted MOP=0 control word, then read back the destination.
  task automatic alu_op(input string tag, input logic [4:0] sa_i, input logic [4:0] sb_i,
                        input logic [4:0] da_i, input logic [2:0] fs_i, input logic c0_i,
                        input logic m_i, input logic [63:0] k_i,
                        input logic [63:0] exp_val, input logic [3:0] exp_stat);
    setcw(sa_i, sb_i, da_i, 1'b1, fs_i, c0_i, m_i, k_i, 2'd0, 1'b0, 2'd0);
    step;
    cw_valid = 1'b0;
    dbg_sel = da_i;
    #1;
    chk({tag, "_val"}, dbg_data, exp_val);
    chk({tag, "_stat"}, {60'd0, STAT}, {60'd0, exp_stat});
  endtask

  initial begin
    RST = 1'b0; cw_valid = 1'b0;
    SA = '0; SB = '0; DA = '0; WR = 1'b0; FS = '0; C0 = 1'b0; M = 1'b0; K = '0;
    PS = '0; PC_SEL = 1'b0; MOP = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; dbg_sel = 5'd1;

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_cw_ready", {63'd0, cw_ready}, 64'd1);
    chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
    chk("rst_pc", {32'd0, PC_OUT}, 64'd0);
    chk("rst_consig", {32'd0, CONSIG}, 64'd0);
    chk("rst_stat", {60'd0, STAT}, 64'd0);
    chk("rst_dbg", dbg_data, 64'd0);
    RST = 1'b1;

    // R1 = R31 + 5, accepted on the first edge after reset release
    setcw(5'd31, 5'd0, 5'd1, 1'b1, 3'd2, 1'b0, 1'b1, 64'd5, 2'd0, 1'b0, 2'd0);
    step;
    cw_valid = 1'b0;
    #1;
    chk("add_r1", dbg_data, 64'd5);
    chk("add_stat", {60'd0, STAT}, 64'd0);
    chk("add_pc_hold", {32'd0, PC_OUT}, 64'd0);
    chk("add_ready", {63'd0, cw_ready}, 64'd1);

    // Write lands at the edge: pre-edge read is the old value
    setcw(5'd31, 5'd0, 5'd2, 1'b1, 3'd7, 1'b0, 1'b1, 64'd7, 2'd0, 1'b0, 2'd0);
    dbg_sel = 5'd2;
    #1;
    chk("r2_old", dbg_data, 64'd0);
    step;
    cw_valid = 1'b0;
    #1;
    chk("r2_new", dbg_data, 64'd7);

    // Register-register ADD with carry in: 5 + 7 + 1
    alu_op("addc", 5'd1, 5'd2, 5'd3, 3'd2, 1'b1, 1'b0, 64'd0, 64'd13, 4'b0000);

    // Store with delayed grant; an offered word during MREQ must be ignored
    setcw(5'd31, 5'd1, 5'd0, 1'b0, 3'd7, 1'b0, 1'b1, 64'h100, 2'd0, 1'b0, 2'd2);
    step;
    setcw(5'd31, 5'd0, 5'd1, 1'b1, 3'd7, 1'b0, 1'b1, 64'h55, 2'd1, 1'b0, 2'd0);
    for (int i = 0; i < 4; i++) begin
      chk("st_req", {63'd0, mem_req}, 64'd1);
      chk("st_addr", {32'd0, mem_addr}, 64'h100);
      chk("st_wdata", mem_wdata, 64'd5);
      chk("st_we", {63'd0, mem_we}, 64'd1);
      chk("st_ready", {63'd0, cw_ready}, 64'd0);
      if (i == 3) mem_gnt = 1'b1;
      step;
    end
    mem_gnt = 1'b0;
    cw_valid = 1'b0;
    dbg_sel = 5'd1;
    #1;
    chk("st_done_req", {63'd0, mem_req}, 64'd0);
    chk("st_done_ready", {63'd0, cw_ready}, 64'd1);
    chk("st_ignored_r1", dbg_data, 64'd5);
    chk("st_ignored_pc", {32'd0, PC_OUT}, 64'd0);

    // Fetch with PS=1; rvalid coincident with grant is not consumed
    setcw(5'd31, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b1, 64'd0, 2'd1, 1'b0, 2'd3);
    step;
    cw_valid = 1'b0;
    chk("fe_addr", {32'd0, mem_addr}, 64'd0);
    chk("fe_pc", {32'd0, PC_OUT}, 64'd4);
    chk("fe_we", {63'd0, mem_we}, 64'd0);
    chk("fe_stat", {60'd0, STAT}, 64'b0001);
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'h11111111;
    step;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    chk("fe_early_rvalid", {32'd0, CONSIG}, 64'd0);
    chk("fe_wait_ready", {63'd0, cw_ready}, 64'd0);
    mem_rvalid = 1'b1; mem_rdata = 64'hDEADBEEF;
    step;
    mem_rvalid = 1'b0;
    chk("fe_consig", {32'd0, CONSIG}, 64'hDEADBEEF);
    chk("fe_done_ready", {63'd0, cw_ready}, 64'd1);

    // Load to R4 at address 0x40
    setcw(5'd31, 5'd0, 5'd4, 1'b1, 3'd7, 1'b0, 1'b1, 64'h40, 2'd0, 1'b0, 2'd1);
    step;
    cw_valid = 1'b0;
    chk("ld_addr", {32'd0, mem_addr}, 64'h40);
    chk("ld_we", {63'd0, mem_we}, 64'd0);
    mem_gnt = 1'b1;
    step;
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h0123456789ABCDEF;
    step;
    mem_rvalid = 1'b0;
    dbg_sel = 5'd4;
    #1;
    chk("ld_r4", dbg_data, 64'h0123456789ABCDEF);

    // ALU functions and flags
    alu_op("sub_neg", 5'd31, 5'd0, 5'd5, 3'd3, 1'b0, 1'b1, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0010);
    alu_op("r31_wr", 5'd31, 5'd0, 5'd31, 3'd3, 1'b0, 1'b1, 64'd1, 64'd0, 4'b0010);
    alu_op("add_carry", 5'd5, 5'd0, 5'd6, 3'd2, 1'b0, 1'b1, 64'd1, 64'd0, 4'b0101);
    alu_op("lsl", 5'd5, 5'd0, 5'd8, 3'd5, 1'b0, 1'b1, 64'd63, 64'h8000_0000_0000_0000, 4'b0010);
    alu_op("sub_ovf", 5'd8, 5'd0, 5'd9, 3'd3, 1'b0, 1'b1, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b1100);
    alu_op("lsr", 5'd8, 5'd0, 5'd10, 3'd6, 1'b0, 1'b1, 64'd4, 64'h0800_0000_0000_0000, 4'b0000);
    alu_op("xor", 5'd2, 5'd0, 5'd11, 3'd4, 1'b0, 1'b1, 64'hF, 64'd8, 4'b0000);
    alu_op("or", 5'd1, 5'd2, 5'd12, 3'd1, 1'b0, 1'b0, 64'd0, 64'd7, 4'b0000);
    alu_op("and", 5'd1, 5'd2, 5'd13, 3'd0, 1'b0, 1'b0, 64'd0, 64'd5, 4'b0000);

    // PC: absolute from K, relative wrap, absolute from A register
    setcw(5'd31, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b1, 64'hFFFF_FFFC, 2'd2, 1'b1, 2'd0);
    step;
    chk("pc_abs_k", {32'd0, PC_OUT}, 64'hFFFF_FFFC);
    setcw(5'd31, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b1, 64'd1, 2'd3, 1'b0, 2'd0);
    step;
    chk("pc_rel_wrap", {32'd0, PC_OUT}, 64'd0);
    setcw(5'd2, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b1, 64'd0, 2'd2, 1'b0, 2'd0);
    step;
    cw_valid = 1'b0;
    chk("pc_abs_a", {32'd0, PC_OUT}, 64'd7);

    // Reset while waiting for fetch data
    setcw(5'd31, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b1, 64'd0, 2'd0, 1'b0, 2'd3);
    step;
    cw_valid = 1'b0;
    chk("rw_fetch_addr", {32'd0, mem_addr}, 64'd7);
    mem_gnt = 1'b1;
    step;
    mem_gnt = 1'b0;
    chk("rw_in_wait", {63'd0, cw_ready}, 64'd0);
    RST = 1'b0;
    dbg_sel = 5'd2;
    #1;
    chk("rw_ready", {63'd0, cw_ready}, 64'd1);
    chk("rw_req", {63'd0, mem_req}, 64'd0);
    chk("rw_pc", {32'd0, PC_OUT}, 64'd0);
    chk("rw_consig", {32'd0, CONSIG}, 64'd0);
    chk("rw_stat", {60'd0, STAT}, 64'd0);
    chk("rw_reg", dbg_data, 64'd0);
    RST = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 64'hCAFEBABE;
    setcw(5'd31, 5'd0, 5'd1, 1'b1, 3'd7, 1'b0, 1'b1, 64'h33, 2'd0, 1'b0, 2'd0);
    step;
    cw_valid = 1'b0; mem_rvalid = 1'b0;
    dbg_sel = 5'd1;
    #1;
    chk("rw_first_accept", dbg_data, 64'h33);
    chk("rw_late_rvalid", {32'd0, CONSIG}, 64'd0);

    // Reset during MREQ drops the request at once
    setcw(5'd31, 5'd1, 5'd0, 1'b0, 3'd7, 1'b0, 1'b1, 64'h200, 2'd0, 1'b0, 2'd2);
    step;
    cw_valid = 1'b0;
    chk("rq_req_before", {63'd0, mem_req}, 64'd1);
    RST = 1'b0;
    #1;
    chk("rq_req_after", {63'd0, mem_req}, 64'd0);
    RST = 1'b1;
    step;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
